// File: rtl/adc_fifo_reader.sv
// adc_fifo_reader: drains the 8-bit read side of the ADC capture FIFO and
// forwards whole samples (high byte, then low byte) to the host-link byte
// transmitter. Framing: high byte has bit 7 set, low byte has bit 7 clear.
// Misframed bytes are dropped and counted, so a split sample never reaches
// the host.
module adc_fifo_reader #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] num_samples_i,
  input  logic                 fifo_empty_i,
  input  logic [7:0]           fifo_dout_i,
  output logic                 fifo_rd_en_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [7:0]           sync_err_cnt_o,
  output logic [CNT_WIDTH-1:0] samples_sent_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    CAPTURE = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state;
  state_t               state_nxt;
  logic                 phase_lo;
  logic                 phase_lo_nxt;
  logic [CNT_WIDTH-1:0] num_q;
  logic [7:0]           hi_reg;
  logic [7:0]           lo_reg;

  logic                 clr_cnt;
  logic                 latch_num;
  logic                 ld_hi;
  logic                 ld_lo;
  logic                 err_inc;
  logic                 sent_inc;
  logic [CNT_WIDTH-1:0] sent_next;

  // Saturating increment for the framing-error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  // Saturating increment for the sample counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign busy_o    = (state != IDLE);
  assign sent_next = sat_inc_cnt(samples_sent_o);

  // Next-state and per-cycle control decode; abort wins in every busy state.
  always_comb begin
    state_nxt    = state;
    phase_lo_nxt = phase_lo;
    clr_cnt      = 1'b0;
    latch_num    = 1'b0;
    ld_hi        = 1'b0;
    ld_lo        = 1'b0;
    err_inc      = 1'b0;
    sent_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          clr_cnt      = 1'b1;
          latch_num    = 1'b1;
          phase_lo_nxt = 1'b0;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (fifo_rd_en_o) begin
          state_nxt = CAPTURE;
        end else if (fifo_empty_i && (num_q == '0) && !phase_lo) begin
          // Drain mode ends only on a sample boundary.
          state_nxt = IDLE;
        end
      end
      CAPTURE: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (!phase_lo) begin
          if (fifo_dout_i[7]) begin
            ld_hi        = 1'b1;
            phase_lo_nxt = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
          state_nxt = REQ;
        end else if (!fifo_dout_i[7]) begin
          ld_lo     = 1'b1;
          state_nxt = SEND_HI;
        end else begin
          // A second high byte restarts the sample; the stale one is dropped.
          err_inc   = 1'b1;
          ld_hi     = 1'b1;
          state_nxt = REQ;
        end
      end
      SEND_HI: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (tx_ready_i) begin
          state_nxt = SEND_LO;
        end
      end
      SEND_LO: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (tx_ready_i) begin
          sent_inc     = 1'b1;
          phase_lo_nxt = 1'b0;
          if ((num_q != '0) && (sent_next == num_q)) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, registered outputs and counters. The read strobe is decided one
  // cycle ahead from the empty flag: only this block reads the FIFO, and the
  // previous read is always at least two cycles old, so a clear empty flag
  // cannot become set before the strobe lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      phase_lo       <= 1'b0;
      fifo_rd_en_o   <= 1'b0;
      tx_valid_o     <= 1'b0;
      tx_data_o      <= 8'd0;
      done_o         <= 1'b0;
      sync_err_cnt_o <= 8'd0;
      samples_sent_o <= '0;
    end else begin
      state        <= state_nxt;
      phase_lo     <= phase_lo_nxt;
      fifo_rd_en_o <= (state_nxt == REQ) && !fifo_empty_i;
      tx_valid_o   <= (state_nxt == SEND_HI) || (state_nxt == SEND_LO);
      done_o       <= (state != IDLE) && (state_nxt == IDLE);
      if (state_nxt == SEND_HI) begin
        tx_data_o <= hi_reg;
      end else if (state_nxt == SEND_LO) begin
        tx_data_o <= lo_reg;
      end
      if (clr_cnt) begin
        sync_err_cnt_o <= 8'd0;
        samples_sent_o <= '0;
      end else begin
        if (err_inc) begin
          sync_err_cnt_o <= sat_inc8(sync_err_cnt_o);
        end
        if (sent_inc) begin
          samples_sent_o <= sent_next;
        end
      end
    end
  end

  // Sample bytes and the latched request length; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (latch_num) begin
      num_q <= num_samples_i;
    end
    if (ld_hi) begin
      hi_reg <= fifo_dout_i;
    end
    if (ld_lo) begin
      lo_reg <= fifo_dout_i;
    end
  end

endmodule

// File: tb/tb_adc_fifo_reader.sv
// Directed testbench for adc_fifo_reader with a simple FIFO read-side model
// and a transmitter-side byte monitor.
module tb_adc_fifo_reader;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic        abort_i;
  logic [15:0] num_samples_i;
  logic        fifo_empty_i;
  logic [7:0]  fifo_dout_i;
  logic        fifo_rd_en_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  sync_err_cnt_o;
  logic [15:0] samples_sent_o;

  logic [7:0] fmem [0:255];
  int         wr_ptr;
  int         rd_ptr;
  int         rd_cnt;
  int         rd_when_empty;
  int         done_cnt;
  logic [7:0] rx_mem [0:255];
  int         rx_cnt;
  int         n_checks;
  int         n_pass;

  adc_fifo_reader #(.CNT_WIDTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .num_samples_i  (num_samples_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_dout_i    (fifo_dout_i),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .sync_err_cnt_o (sync_err_cnt_o),
    .samples_sent_o (samples_sent_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read side: data one cycle after the strobe, empty flag follows the pointers.
  always @(posedge clk) begin
    if (fifo_rd_en_o) begin
      rd_cnt <= rd_cnt + 1;
    end
    if (fifo_rd_en_o && (rd_ptr != wr_ptr)) begin
      fifo_dout_i  <= fmem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
      fifo_empty_i <= ((rd_ptr + 1) == wr_ptr);
    end else begin
      if (fifo_rd_en_o) begin
        rd_when_empty <= rd_when_empty + 1;
      end
      fifo_empty_i <= (rd_ptr == wr_ptr);
    end
  end

  // Transmitter side: record accepted bytes and done pulses.
  always @(posedge clk) begin
    if (tx_valid_o && tx_ready_i) begin
      rx_mem[rx_cnt[7:0]] <= tx_data_o;
      rx_cnt              <= rx_cnt + 1;
    end
    if (done_o) begin
      done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    num_samples_i = n;
    start_i       = 1'b1;
    @(negedge clk);
    start_i       = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (tx_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic rx_pack(input int base, input int n, output logic [63:0] w);
    w = 64'd0;
    for (int i = 0; i < n; i++) begin
      w = {w[55:0], rx_mem[(base + i) % 256]};
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, tx_valid_o, fifo_rd_en_o} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {busy_o, done_o, tx_valid_o, fifo_rd_en_o});
    else n_pass++;
    n_checks++;
    if ({tx_data_o, sync_err_cnt_o, samples_sent_o} !== 32'd0)
      $display("FAIL reset_data: got %h want 0", {tx_data_o, sync_err_cnt_o, samples_sent_o});
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy_o, done_o} !== 2'b00)
      $display("FAIL post_reset_idle: got %b want 00", {busy_o, done_o});
    else n_pass++;
  endtask

  task automatic test_basic;
    int rd0, rx0, dn0;
    bit ok;
    logic [63:0] w;
    rd0 = rd_cnt; rx0 = rx_cnt; dn0 = done_cnt;
    tx_ready_i = 1'b1;
    push(8'h83); push(8'h2A); push(8'h80); push(8'h05);
    @(negedge clk);
    pulse_start(16'd2);
    n_checks++;
    if ({busy_o, fifo_rd_en_o} !== 2'b11)
      $display("FAIL basic_c1_req: got %b want 11", {busy_o, fifo_rd_en_o});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (fifo_rd_en_o !== 1'b0) $display("FAIL basic_c2_capture: rd_en %b want 0", fifo_rd_en_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (fifo_rd_en_o !== 1'b1) $display("FAIL basic_c3_req: rd_en %b want 1", fifo_rd_en_o);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx_valid_o, tx_data_o} !== {1'b1, 8'h83})
      $display("FAIL basic_c5_hi: got %h want 183", {tx_valid_o, tx_data_o});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({tx_valid_o, tx_data_o} !== {1'b1, 8'h2A})
      $display("FAIL basic_c6_lo: got %h want 12a", {tx_valid_o, tx_data_o});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({fifo_rd_en_o, samples_sent_o} !== {1'b1, 16'd1})
      $display("FAIL basic_c7_next: got %h want 10001", {fifo_rd_en_o, samples_sent_o});
    else n_pass++;
    wait_done(40, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL basic_done: done seen %b want 1", ok);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done_o, busy_o} !== 2'b00) $display("FAIL basic_done_len: got %b want 00", {done_o, busy_o});
    else n_pass++;
    rx_pack(rx0, 4, w);
    n_checks++;
    if ((rx_cnt - rx0) !== 4 || w[31:0] !== 32'h832A8005)
      $display("FAIL basic_bytes: got %0d bytes %h want 4 bytes 832a8005", rx_cnt - rx0, w[31:0]);
    else n_pass++;
    n_checks++;
    if ({samples_sent_o, sync_err_cnt_o} !== {16'd2, 8'd0})
      $display("FAIL basic_counters: got %h want 000200", {samples_sent_o, sync_err_cnt_o});
    else n_pass++;
    n_checks++;
    if ((rd_cnt - rd0) !== 4 || (done_cnt - dn0) !== 1)
      $display("FAIL basic_reads_done: got reads %0d done %0d want 4 1", rd_cnt - rd0, done_cnt - dn0);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int rd0, rx0, bad;
    bit ok;
    logic [63:0] w;
    rd0 = rd_cnt; rx0 = rx_cnt; bad = 0;
    tx_ready_i = 1'b0;
    push(8'h83); push(8'h2A); push(8'h80); push(8'h05);
    @(negedge clk);
    pulse_start(16'd2);
    wait_valid(20, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL bp_valid: tx_valid seen %b want 1", ok);
    else n_pass++;
    repeat (10) begin
      @(negedge clk);
      if (!(tx_valid_o === 1'b1 && tx_data_o === 8'h83)) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if ((rd_cnt - rd0) !== 2) $display("FAIL bp_no_extra_reads: got %0d want 2", rd_cnt - rd0);
    else n_pass++;
    tx_ready_i = 1'b1;
    wait_done(40, ok);
    @(negedge clk);
    rx_pack(rx0, 4, w);
    n_checks++;
    if (ok !== 1'b1 || (rx_cnt - rx0) !== 4 || w[31:0] !== 32'h832A8005)
      $display("FAIL bp_bytes: done %b got %0d bytes %h want 1 4 832a8005", ok, rx_cnt - rx0, w[31:0]);
    else n_pass++;
    n_checks++;
    if ((rd_cnt - rd0) !== 4 || samples_sent_o !== 16'd2)
      $display("FAIL bp_totals: got reads %0d samples %0d want 4 2", rd_cnt - rd0, samples_sent_o);
    else n_pass++;
  endtask

  task automatic test_framing;
    int rd0, rx0;
    bit ok;
    logic [63:0] w;
    rd0 = rd_cnt; rx0 = rx_cnt;
    tx_ready_i = 1'b1;
    push(8'h12); push(8'h81); push(8'h90); push(8'h33);
    @(negedge clk);
    pulse_start(16'd1);
    wait_done(40, ok);
    @(negedge clk);
    rx_pack(rx0, 2, w);
    n_checks++;
    if (ok !== 1'b1 || (rx_cnt - rx0) !== 2 || w[15:0] !== 16'h9033)
      $display("FAIL frame_bytes: done %b got %0d bytes %h want 1 2 9033", ok, rx_cnt - rx0, w[15:0]);
    else n_pass++;
    n_checks++;
    if (sync_err_cnt_o !== 8'd2) $display("FAIL frame_errcnt: got %0d want 2", sync_err_cnt_o);
    else n_pass++;
    n_checks++;
    if ((rd_cnt - rd0) !== 4 || samples_sent_o !== 16'd1)
      $display("FAIL frame_totals: got reads %0d samples %0d want 4 1", rd_cnt - rd0, samples_sent_o);
    else n_pass++;
  endtask

  task automatic test_drain;
    int rd0, rx0, dn0;
    bit ok;
    logic [63:0] w;
    rd0 = rd_cnt; rx0 = rx_cnt; dn0 = done_cnt;
    tx_ready_i = 1'b1;
    push(8'hA1); push(8'h11); push(8'hB2); push(8'h22); push(8'hC3); push(8'h33);
    @(negedge clk);
    pulse_start(16'd0);
    wait_done(100, ok);
    @(negedge clk);
    rx_pack(rx0, 6, w);
    n_checks++;
    if (ok !== 1'b1 || (rx_cnt - rx0) !== 6 || w[47:0] !== 48'hA111B222C333)
      $display("FAIL drain_bytes: done %b got %0d bytes %h want 1 6 a111b222c333", ok, rx_cnt - rx0, w[47:0]);
    else n_pass++;
    n_checks++;
    if (samples_sent_o !== 16'd3 || (done_cnt - dn0) !== 1)
      $display("FAIL drain_totals: got samples %0d done %0d want 3 1", samples_sent_o, done_cnt - dn0);
    else n_pass++;
    rd0 = rd_cnt;
    pulse_start(16'd0);
    n_checks++;
    if ({busy_o, done_o} !== 2'b10) $display("FAIL drain_empty_c1: got %b want 10", {busy_o, done_o});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy_o, done_o} !== 2'b01) $display("FAIL drain_empty_c2: got %b want 01", {busy_o, done_o});
    else n_pass++;
    n_checks++;
    if (samples_sent_o !== 16'd0 || (rd_cnt - rd0) !== 0)
      $display("FAIL drain_empty_totals: got samples %0d reads %0d want 0 0", samples_sent_o, rd_cnt - rd0);
    else n_pass++;
  endtask

  task automatic test_abort;
    int rd0;
    bit ok;
    tx_ready_i = 1'b0;
    push(8'h12); push(8'h83); push(8'h2A);
    @(negedge clk);
    pulse_start(16'd1);
    wait_valid(30, ok);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    n_checks++;
    if ({ok, tx_valid_o, done_o, busy_o} !== 4'b1010)
      $display("FAIL abort_exit: got %b want 1010", {ok, tx_valid_o, done_o, busy_o});
    else n_pass++;
    n_checks++;
    if ({sync_err_cnt_o, samples_sent_o} !== {8'd1, 16'd0})
      $display("FAIL abort_counters_kept: got %h want 010000", {sync_err_cnt_o, samples_sent_o});
    else n_pass++;
    @(negedge clk);
    rd0 = rd_cnt;
    push(8'h83); push(8'h2A);
    @(negedge clk);
    pulse_start(16'd1);
    wait_valid(30, ok);
    num_samples_i = 16'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_checks++;
    if ({ok, tx_valid_o, tx_data_o} !== {2'b11, 8'h83})
      $display("FAIL busy_start_ignored: got %h want 383", {ok, tx_valid_o, tx_data_o});
    else n_pass++;
    tx_ready_i = 1'b1;
    wait_done(30, ok);
    n_checks++;
    if (ok !== 1'b1 || samples_sent_o !== 16'd1 || (rd_cnt - rd0) !== 2)
      $display("FAIL busy_start_num: done %b samples %0d reads %0d want 1 1 2", ok, samples_sent_o, rd_cnt - rd0);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int dn0;
    tx_ready_i = 1'b1;
    push(8'h83); push(8'h2A); push(8'h80);
    @(negedge clk);
    pulse_start(16'd2);
    repeat (7) @(negedge clk);
    n_checks++;
    if ({busy_o, samples_sent_o, tx_data_o} !== {1'b1, 16'd1, 8'h2A})
      $display("FAIL rst_mid_pre: got %h want 100012a", {busy_o, samples_sent_o, tx_data_o});
    else n_pass++;
    dn0 = done_cnt;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, done_o, tx_valid_o, fifo_rd_en_o, tx_data_o, sync_err_cnt_o, samples_sent_o} !== 36'd0)
      $display("FAIL rst_mid_async: got %h want 0",
               {busy_o, done_o, tx_valid_o, fifo_rd_en_o, tx_data_o, sync_err_cnt_o, samples_sent_o});
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ((done_cnt - dn0) !== 0 || busy_o !== 1'b0)
      $display("FAIL rst_mid_no_done: got done %0d busy %b want 0 0", done_cnt - dn0, busy_o);
    else n_pass++;
  endtask

  task automatic test_empty_stall;
    int rd0, rx0, bad;
    bit ok;
    logic [63:0] w;
    rd0 = rd_cnt; rx0 = rx_cnt; bad = 0;
    tx_ready_i = 1'b1;
    pulse_start(16'd1);
    for (int i = 0; i < 20; i++) begin
      if (fifo_rd_en_o !== 1'b0 || busy_o !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0 || (rd_cnt - rd0) !== 0)
      $display("FAIL stall_idle: got bad %0d reads %0d want 0 0", bad, rd_cnt - rd0);
    else n_pass++;
    push(8'h83); push(8'h2A);
    wait_done(30, ok);
    @(negedge clk);
    rx_pack(rx0, 2, w);
    n_checks++;
    if (ok !== 1'b1 || (rx_cnt - rx0) !== 2 || w[15:0] !== 16'h832A)
      $display("FAIL stall_bytes: done %b got %0d bytes %h want 1 2 832a", ok, rx_cnt - rx0, w[15:0]);
    else n_pass++;
    n_checks++;
    if (samples_sent_o !== 16'd1 || (rd_cnt - rd0) !== 2)
      $display("FAIL stall_totals: got samples %0d reads %0d want 1 2", samples_sent_o, rd_cnt - rd0);
    else n_pass++;
  endtask

  initial begin
    reset_n       = 1'b0;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    num_samples_i = 16'd0;
    tx_ready_i    = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_framing();
    test_drain();
    test_abort();
    test_reset_mid();
    test_empty_stall();
    n_checks++;
    if (rd_when_empty !== 0) $display("FAIL read_while_empty: got %0d want 0", rd_when_empty);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
